d5m_sensor_emulator: RTL and testbench
======================================

Name: d5m_sensor_emulator

Overview:
- Synthesizable emulator of the TRDB_D5M camera side of the sensor link. It drives pixel clock, 12-bit pixel data, LVAL, FVAL and snapshot strobe toward our capture/driver logic.
- Used in place of the real daughter board for bring-up, loopback and regression of the capture path.
- Frame geometry is parameterized. It supports continuous mode and snapshot (trigger) mode.
- One clock; the pixel clock is generated at half rate.

Parameters:
- COLS, 640, active pixels per line (>=2).
- ROWS, 480, active lines per frame (>=1).
- H_BLANK, 16, blank pixel ticks between lines (>=1).
- V_BLANK_ROWS, 8, blank line periods between frames (>=1).
- STROBE_TICKS, 32, pixel ticks of strobe before a snapshot frame (>=1).

Ports:
- ul1Clock  input  1  system clock.
- ul1Reset  input  1  asynchronous, active-high reset.
- ul1Enable  input  1  run enable, sampled at frame boundaries.
- ul1SnapshotMode  input  1  1 = trigger mode, 0 = continuous; sampled at frame boundaries.
- ul2PatternSel  input  2  test pattern select, sampled at frame start.
- ul1Resetn  input  1  sensor reset from driver, active low.
- ul1SnapshotTrigger  input  1  snapshot trigger from driver; rising edge is significant.
- ul1PixelClock  output  1  generated pixel clock, ul1Clock/2.
- ul12PixelData  output  12  pixel data.
- ul1LineValid  output  1  LVAL.
- ul1FrameValid  output  1  FVAL.
- ul1SnapshotStrobe  output  1  exposure strobe.
- ul16FrameCount  output  16  completed frames, wraps.

Behaviour:
- Reset (ul1Reset=1, async): all outputs 0, FSM=IDLE, counters 0, trigger edge register 0.
- Pixel clock:
  - Register toggles every ul1Clock while ul1Reset=0, including while ul1Resetn=0.
  - "Tick" = a cycle where ul1PixelClock is currently 1.
  - All data, LVAL, FVAL and strobe updates occur only on ticks (registered). They are therefore stable across each pixel clock rising edge, with 1 clk setup and 1 clk hold.
- ul1Resetn=0: synchronously forces FSM=IDLE, counters 0, data/LVAL/FVAL/strobe 0. ul16FrameCount is held, not cleared. This takes effect mid-frame with no completion.
- FSM states: IDLE, WAIT_TRIG, STROBE, FRAME, VBLANK.
  - IDLE, on tick, if ul1Enable & ul1Resetn: continuous mode -> FRAME; snapshot mode -> WAIT_TRIG.
  - WAIT_TRIG:
    - Trigger rising edge is detected each clock against a registered copy and latched as pending.
    - On the next tick with pending set -> STROBE; pending clears.
    - ul1Enable=0 -> IDLE.
  - STROBE: strobe=1 for exactly STROBE_TICKS ticks, then -> FRAME.
  - FRAME:
    - Column counter 0..COLS+H_BLANK-1; row counter 0..ROWS-1.
    - LVAL=1 for col<COLS. FVAL=1 from col 0 of row 0 through the last active pixel of row ROWS-1. The trailing H_BLANK of the last row is not inside FVAL.
    - After the last active pixel -> VBLANK; ul16FrameCount increments on the tick FVAL falls.
  - VBLANK:
    - Lasts H_BLANK + V_BLANK_ROWS*(COLS+H_BLANK) ticks with FVAL=LVAL=0.
    - At end: ul1Enable=0 -> IDLE; snapshot -> WAIT_TRIG; else -> FRAME.
- Trigger edges in STROBE/FRAME/VBLANK are ignored; pending is cleared on entry to WAIT_TRIG.
- Pattern (latched at frame start; x=col, y=row, all mod 4096):
  - 0: x.
  - 1: y.
  - 2: x+y+frame[11:0].
  - 3: 12'hFFF.
  - Data is 0 whenever LVAL=0.
- Mode/enable changes mid-frame take effect only at the VBLANK end.

Test Plan:
- Params COLS=4, ROWS=3, H_BLANK=2, V_BLANK_ROWS=1, continuous, pattern 0 -> FVAL high 16 ticks (32 clk); three LVAL pulses of 8 clk separated by 4 clk; data 0,1,2,3 per line; frame period 48 clk; ul16FrameCount 0->1->2.
- Pattern 2 on frame 1, row 2, col 3 -> data 6; pattern 3 -> 12'hFFF during LVAL, 0 in blanking.
- Snapshot mode, STROBE_TICKS=5, single trigger pulse -> strobe high 10 clk, then exactly one frame, then return to WAIT_TRIG. A second trigger during the frame produces no extra frame.
- ul1Resetn low mid-line (row 1, col 2) -> next tick: FVAL=LVAL=data=0, FSM IDLE, frame count held. Release -> new frame starts at row 0 col 0.
- ul1Enable deasserted mid-frame -> current frame and VBLANK complete, then stays idle with FVAL=0; re-enable restarts.
- Async ul1Reset asserted mid-frame between clock edges -> all outputs 0 immediately, ul16FrameCount=0.

Source files
------------

// File: rtl/d5m_sensor_emulator.sv
`default_nettype none
// ============================================================================
// Module   : d5m_sensor_emulator
// Purpose  : TRDB_D5M camera-side emulator: pixel clock, 12-bit data,
//            LVAL/FVAL and snapshot strobe with test patterns.
// Revision : 1.0  initial release
// ============================================================================
module d5m_sensor_emulator #(
  parameter int COLS         = 640,
  parameter int ROWS         = 480,
  parameter int H_BLANK      = 16,
  parameter int V_BLANK_ROWS = 8,
  parameter int STROBE_TICKS = 32
) (
  input  logic        ul1Clock,
  input  logic        ul1Reset,
  input  logic        ul1Enable,
  input  logic        ul1SnapshotMode,
  input  logic [1:0]  ul2PatternSel,
  input  logic        ul1Resetn,
  input  logic        ul1SnapshotTrigger,
  output logic        ul1PixelClock,
  output logic [11:0] ul12PixelData,
  output logic        ul1LineValid,
  output logic        ul1FrameValid,
  output logic        ul1SnapshotStrobe,
  output logic [15:0] ul16FrameCount
);

  localparam int c_LINE_TICKS   = COLS + H_BLANK;
  localparam int c_VBLANK_TICKS = H_BLANK + V_BLANK_ROWS * c_LINE_TICKS;
  localparam int c_COL_W        = $clog2(c_LINE_TICKS + 1);
  localparam int c_ROW_W        = $clog2(ROWS + 1);
  localparam int c_VB_W         = $clog2(c_VBLANK_TICKS + 1);
  localparam int c_STB_W        = $clog2(STROBE_TICKS + 1);

  localparam logic [c_COL_W-1:0] c_LAST_COL_POS    = c_COL_W'(c_LINE_TICKS - 1);
  localparam logic [c_COL_W-1:0] c_LAST_ACTIVE_COL = c_COL_W'(COLS - 1);
  localparam logic [c_COL_W-1:0] c_ACTIVE_COLS     = c_COL_W'(COLS);
  localparam logic [c_ROW_W-1:0] c_LAST_ROW        = c_ROW_W'(ROWS - 1);
  localparam logic [c_VB_W-1:0]  c_LAST_VB         = c_VB_W'(c_VBLANK_TICKS - 1);
  localparam logic [c_STB_W-1:0] c_LAST_STB        = c_STB_W'(STROBE_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TRIG = 3'd1,
    STROBE    = 3'd2,
    FRAME     = 3'd3,
    VBLANK    = 3'd4
  } fsmState_t;

  fsmState_t          r_state, w_nextState;
  logic               r_pixClk;
  logic               r_trigQ;
  logic               r_pending, w_pending;
  logic [c_COL_W-1:0] r_col, w_col;
  logic [c_ROW_W-1:0] r_row, w_row;
  logic [c_VB_W-1:0]  r_vbCount, w_vbCount;
  logic [c_STB_W-1:0] r_stbCount, w_stbCount;
  logic [1:0]         r_pattern, w_pattern;
  logic [11:0]        r_data, w_data;
  logic               r_lval, w_lval;
  logic               r_fval, w_fval;
  logic               r_strobe, w_strobe;
  logic [15:0]        r_frameCount, w_frameCount;

  logic               w_tick;
  logic               w_trigRise;
  logic               w_enterFrame;
  logic               w_colWrap;
  logic               w_lastPixel;
  logic [c_COL_W-1:0] w_advCol;
  logic [c_ROW_W-1:0] w_advRow;

  function automatic logic [11:0] pixelValue(
    input logic [1:0]  pat,
    input logic [11:0] x,
    input logic [11:0] y,
    input logic [11:0] f
  );
    case (pat)
      2'd0:    pixelValue = x;
      2'd1:    pixelValue = y;
      2'd2:    pixelValue = x + y + f;
      default: pixelValue = 12'hFFF;
    endcase
  endfunction

  assign w_tick      = r_pixClk;
  assign w_trigRise  = ul1SnapshotTrigger & ~r_trigQ;
  assign w_colWrap   = (r_col == c_LAST_COL_POS);
  assign w_lastPixel = (r_col == c_LAST_ACTIVE_COL) && (r_row == c_LAST_ROW);
  assign w_advCol    = w_colWrap ? '0 : r_col + 1'b1;
  assign w_advRow    = w_colWrap ? r_row + 1'b1 : r_row;

  // Counters always describe the pixel currently on the outputs.
  always_comb begin
    w_nextState  = r_state;
    w_col        = r_col;
    w_row        = r_row;
    w_vbCount    = r_vbCount;
    w_stbCount   = r_stbCount;
    w_pattern    = r_pattern;
    w_data       = r_data;
    w_lval       = r_lval;
    w_fval       = r_fval;
    w_strobe     = r_strobe;
    w_frameCount = r_frameCount;
    w_pending    = r_pending | ((r_state == WAIT_TRIG) & w_trigRise);
    w_enterFrame = 1'b0;

    if (w_tick) begin
      if (!ul1Resetn) begin
        w_nextState = IDLE;
        w_col       = '0;
        w_row       = '0;
        w_vbCount   = '0;
        w_stbCount  = '0;
        w_data      = '0;
        w_lval      = 1'b0;
        w_fval      = 1'b0;
        w_strobe    = 1'b0;
        w_pending   = 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (ul1Enable) begin
              if (ul1SnapshotMode) begin
                w_nextState = WAIT_TRIG;
                w_pending   = 1'b0;
              end else begin
                w_enterFrame = 1'b1;
              end
            end
          end
          WAIT_TRIG: begin
            if (!ul1Enable) begin
              w_nextState = IDLE;
            end else if (r_pending) begin
              w_nextState = STROBE;
              w_strobe    = 1'b1;
              w_stbCount  = '0;
              w_pending   = 1'b0;
            end
          end
          STROBE: begin
            if (r_stbCount == c_LAST_STB) begin
              w_enterFrame = 1'b1;
            end else begin
              w_stbCount = r_stbCount + 1'b1;
            end
          end
          FRAME: begin
            if (w_lastPixel) begin
              w_nextState  = VBLANK;
              w_vbCount    = '0;
              w_data       = '0;
              w_lval       = 1'b0;
              w_fval       = 1'b0;
              w_frameCount = r_frameCount + 16'd1;
            end else begin
              w_col  = w_advCol;
              w_row  = w_advRow;
              w_fval = 1'b1;
              w_lval = (w_advCol < c_ACTIVE_COLS);
              w_data = w_lval ? pixelValue(r_pattern, 12'(w_advCol), 12'(w_advRow),
                                           r_frameCount[11:0]) : 12'd0;
            end
          end
          VBLANK: begin
            if (r_vbCount == c_LAST_VB) begin
              if (!ul1Enable) begin
                w_nextState = IDLE;
              end else if (ul1SnapshotMode) begin
                w_nextState = WAIT_TRIG;
                w_pending   = 1'b0;
              end else begin
                w_enterFrame = 1'b1;
              end
            end else begin
              w_vbCount = r_vbCount + 1'b1;
            end
          end
          default: w_nextState = IDLE;
        endcase

        // Pattern is latched here and pixel (0,0) is presented on the same tick.
        if (w_enterFrame) begin
          w_nextState = FRAME;
          w_col       = '0;
          w_row       = '0;
          w_pattern   = ul2PatternSel;
          w_strobe    = 1'b0;
          w_fval      = 1'b1;
          w_lval      = 1'b1;
          w_data      = pixelValue(ul2PatternSel, 12'd0, 12'd0, r_frameCount[11:0]);
        end
      end
    end
  end

  always_ff @(posedge ul1Clock or posedge ul1Reset) begin
    if (ul1Reset) begin
      r_state      <= IDLE;
      r_pixClk     <= 1'b0;
      r_trigQ      <= 1'b0;
      r_pending    <= 1'b0;
      r_col        <= '0;
      r_row        <= '0;
      r_vbCount    <= '0;
      r_stbCount   <= '0;
      r_pattern    <= '0;
      r_data       <= '0;
      r_lval       <= 1'b0;
      r_fval       <= 1'b0;
      r_strobe     <= 1'b0;
      r_frameCount <= '0;
    end else begin
      r_state      <= w_nextState;
      r_pixClk     <= ~r_pixClk;
      r_trigQ      <= ul1SnapshotTrigger;
      r_pending    <= w_pending;
      r_col        <= w_col;
      r_row        <= w_row;
      r_vbCount    <= w_vbCount;
      r_stbCount   <= w_stbCount;
      r_pattern    <= w_pattern;
      r_data       <= w_data;
      r_lval       <= w_lval;
      r_fval       <= w_fval;
      r_strobe     <= w_strobe;
      r_frameCount <= w_frameCount;
    end
  end

  assign ul1PixelClock     = r_pixClk;
  assign ul12PixelData     = r_data;
  assign ul1LineValid      = r_lval;
  assign ul1FrameValid     = r_fval;
  assign ul1SnapshotStrobe = r_strobe;
  assign ul16FrameCount    = r_frameCount;

endmodule
`default_nettype wire

// File: tb/tb_d5m_sensor_emulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_d5m_sensor_emulator
// Purpose  : Directed self-checking bench for d5m_sensor_emulator (4x3 frame).
// Revision : 1.0  initial release
// ============================================================================
module tb_d5m_sensor_emulator;

  localparam int COLS         = 4;
  localparam int ROWS         = 3;
  localparam int H_BLANK      = 2;
  localparam int V_BLANK_ROWS = 1;
  localparam int STROBE_TICKS = 5;
  localparam int LINE         = 6;
  localparam int FVAL_TICKS   = 16;
  localparam int FRAME_TICKS  = 24;

  logic        ul1Clock = 1'b0;
  logic        ul1Reset;
  logic        ul1Enable;
  logic        ul1SnapshotMode;
  logic [1:0]  ul2PatternSel;
  logic        ul1Resetn;
  logic        ul1SnapshotTrigger;
  logic        ul1PixelClock;
  logic [11:0] ul12PixelData;
  logic        ul1LineValid;
  logic        ul1FrameValid;
  logic        ul1SnapshotStrobe;
  logic [15:0] ul16FrameCount;

  int vectors     = 0;
  int miscompares = 0;

  int   clkCnt = 0, lastRise = 0, framePeriod = 0;
  int   fvRun = 0, fvLen = 0, lvRun = 0, lvLen = 0;
  int   gapRun = 0, gapLen = 0, stbRun = 0, stbLen = 0;
  logic fvPrev = 1'b0;

  d5m_sensor_emulator #(
    .COLS(COLS), .ROWS(ROWS), .H_BLANK(H_BLANK),
    .V_BLANK_ROWS(V_BLANK_ROWS), .STROBE_TICKS(STROBE_TICKS)
  ) dut (
    .ul1Clock(ul1Clock),
    .ul1Reset(ul1Reset),
    .ul1Enable(ul1Enable),
    .ul1SnapshotMode(ul1SnapshotMode),
    .ul2PatternSel(ul2PatternSel),
    .ul1Resetn(ul1Resetn),
    .ul1SnapshotTrigger(ul1SnapshotTrigger),
    .ul1PixelClock(ul1PixelClock),
    .ul12PixelData(ul12PixelData),
    .ul1LineValid(ul1LineValid),
    .ul1FrameValid(ul1FrameValid),
    .ul1SnapshotStrobe(ul1SnapshotStrobe),
    .ul16FrameCount(ul16FrameCount)
  );

  always #5 ul1Clock = ~ul1Clock;

  // Pulse-width and period measurement in system clocks.
  always @(negedge ul1Clock) begin
    clkCnt <= clkCnt + 1;
    fvPrev <= ul1FrameValid;
    if (ul1FrameValid && !fvPrev) begin
      framePeriod <= clkCnt - lastRise;
      lastRise    <= clkCnt;
    end
    fvRun <= ul1FrameValid ? fvRun + 1 : 0;
    if (!ul1FrameValid && fvRun != 0) fvLen <= fvRun;
    lvRun <= ul1LineValid ? lvRun + 1 : 0;
    if (!ul1LineValid && lvRun != 0) lvLen <= lvRun;
    gapRun <= (ul1FrameValid && !ul1LineValid) ? gapRun + 1 : 0;
    if (!(ul1FrameValid && !ul1LineValid) && gapRun != 0) gapLen <= gapRun;
    stbRun <= ul1SnapshotStrobe ? stbRun + 1 : 0;
    if (!ul1SnapshotStrobe && stbRun != 0) stbLen <= stbRun;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the negedge following the next pixel-clock tick edge.
  task automatic tick();
    if (ul1PixelClock) begin
      @(posedge ul1Clock);
    end else begin
      @(posedge ul1Clock);
      @(posedge ul1Clock);
    end
    @(negedge ul1Clock);
  endtask

  // Starts at the negedge after the frame-entry tick; ends on the last VBLANK tick.
  // act: 1 drop enable, 2 pulse trigger, 3 select snapshot mode.
  task automatic checkFrame(input int pat, input int frm, input int actAt, input int act,
                            input logic [1:0] nextPat);
    int          row, col;
    logic        lv, fv;
    logic [11:0] d;
    for (int i = 0; i < FRAME_TICKS; i++) begin
      if (i > 0) tick();
      if (i < FVAL_TICKS) begin
        row = i / LINE; col = i % LINE; fv = 1'b1; lv = (col < COLS);
      end else begin
        row = 0; col = 0; fv = 1'b0; lv = 1'b0;
      end
      case (pat)
        0:       d = 12'(col);
        1:       d = 12'(row);
        2:       d = 12'(col + row + frm);
        default: d = 12'hFFF;
      endcase
      if (!lv) d = 12'd0;
      chk1($sformatf("f%0d_fval@%0d", frm, i), ul1FrameValid, fv);
      chk1($sformatf("f%0d_lval@%0d", frm, i), ul1LineValid, lv);
      chk16($sformatf("f%0d_data@%0d", frm, i), 16'(ul12PixelData), 16'(d));
      chk16($sformatf("f%0d_count@%0d", frm, i), ul16FrameCount,
            16'((i < FVAL_TICKS) ? frm : frm + 1));
      chk1($sformatf("f%0d_strobe@%0d", frm, i), ul1SnapshotStrobe, 1'b0);
      if (i == actAt) begin
        case (act)
          1:       ul1Enable = 1'b0;
          2:       ul1SnapshotTrigger = 1'b1;
          3:       ul1SnapshotMode = 1'b1;
          default: ;
        endcase
      end
      if (act == 2 && i == actAt + 1) ul1SnapshotTrigger = 1'b0;
      if (i == 20) ul2PatternSel = nextPat;
    end
  endtask

  task automatic waitStrobe(input string tag);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 4 && !found; k++) begin
      tick();
      found = ul1SnapshotStrobe;
    end
    chk1(tag, ul1SnapshotStrobe, 1'b1);
  endtask

  initial begin
    int   row, col;
    logic lv;

    ul1Reset = 1'b1; ul1Enable = 1'b0; ul1SnapshotMode = 1'b0;
    ul2PatternSel = 2'd0; ul1Resetn = 1'b1; ul1SnapshotTrigger = 1'b0;
    repeat (3) @(negedge ul1Clock);
    chk1("rst_pixclk", ul1PixelClock, 1'b0);
    chk1("rst_fval", ul1FrameValid, 1'b0);
    chk1("rst_lval", ul1LineValid, 1'b0);
    chk1("rst_strobe", ul1SnapshotStrobe, 1'b0);
    chk16("rst_data", 16'(ul12PixelData), 16'd0);
    chk16("rst_count", ul16FrameCount, 16'd0);

    ul1Reset = 1'b0;
    @(negedge ul1Clock); chk1("pixclk_hi", ul1PixelClock, 1'b1);
    @(negedge ul1Clock); chk1("pixclk_lo", ul1PixelClock, 1'b0);
    tick(); chk1("idle_fval", ul1FrameValid, 1'b0);

    // Continuous mode: pattern 0, then 2, then 3 with enable dropped mid-frame.
    ul1Enable = 1'b1;
    tick();
    checkFrame(0, 0, -1, 0, 2'd2);
    tick();
    checkFrame(2, 1, -1, 0, 2'd3);
    chk16("fval_clks", 16'(fvLen), 16'd32);
    chk16("lval_clks", 16'(lvLen), 16'd8);
    chk16("lval_gap_clks", 16'(gapLen), 16'd4);
    chk16("frame_period_clks", 16'(framePeriod), 16'd48);
    tick();
    checkFrame(3, 2, 5, 1, 2'd1);
    tick();
    for (int k = 0; k < 6; k++) begin
      chk1($sformatf("disabled_fval%0d", k), ul1FrameValid, 1'b0);
      chk1($sformatf("disabled_lval%0d", k), ul1LineValid, 1'b0);
      chk16($sformatf("disabled_count%0d", k), ul16FrameCount, 16'd3);
      tick();
    end

    // Re-enable with pattern 1, then sensor reset at row 1 col 2.
    ul1Enable = 1'b1;
    tick();
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) tick();
      row = i / LINE; col = i % LINE; lv = (col < COLS);
      chk1($sformatf("reen_fval@%0d", i), ul1FrameValid, 1'b1);
      chk1($sformatf("reen_lval@%0d", i), ul1LineValid, lv);
      chk16($sformatf("reen_data@%0d", i), 16'(ul12PixelData), lv ? 16'(row) : 16'd0);
    end
    ul1Resetn = 1'b0;
    tick();
    chk1("resetn_fval", ul1FrameValid, 1'b0);
    chk1("resetn_lval", ul1LineValid, 1'b0);
    chk16("resetn_data", 16'(ul12PixelData), 16'd0);
    chk16("resetn_count", ul16FrameCount, 16'd3);
    chk1("resetn_pixclk_lo", ul1PixelClock, 1'b0);
    @(negedge ul1Clock); chk1("resetn_pixclk_hi", ul1PixelClock, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk1($sformatf("resetn_hold_fval%0d", k), ul1FrameValid, 1'b0);
    end
    ul2PatternSel = 2'd0;
    ul1Resetn = 1'b1;
    tick();
    checkFrame(0, 3, 2, 3, 2'd2);

    // Snapshot mode: one trigger gives strobe + exactly one frame.
    tick();
    for (int k = 0; k < 3; k++) begin
      chk1($sformatf("wait_fval%0d", k), ul1FrameValid, 1'b0);
      chk1($sformatf("wait_strobe%0d", k), ul1SnapshotStrobe, 1'b0);
      tick();
    end
    ul1SnapshotTrigger = 1'b1;
    @(negedge ul1Clock);
    ul1SnapshotTrigger = 1'b0;
    waitStrobe("strobe_start");
    for (int k = 1; k < STROBE_TICKS; k++) begin
      tick();
      chk1($sformatf("strobe_on%0d", k), ul1SnapshotStrobe, 1'b1);
      chk1($sformatf("strobe_fval%0d", k), ul1FrameValid, 1'b0);
    end
    tick();
    chk1("strobe_off", ul1SnapshotStrobe, 1'b0);
    chk1("snap_fval", ul1FrameValid, 1'b1);
    chk16("snap_data", 16'(ul12PixelData), 16'd4);
    checkFrame(2, 4, 3, 2, 2'd2);
    chk16("strobe_clks", 16'(stbLen), 16'd10);
    for (int k = 0; k < 40; k++) begin
      tick();
      chk1($sformatf("one_shot_fval%0d", k), ul1FrameValid, 1'b0);
      chk1($sformatf("one_shot_strobe%0d", k), ul1SnapshotStrobe, 1'b0);
    end

    // Async reset between clock edges, mid-frame.
    ul1SnapshotTrigger = 1'b1;
    @(negedge ul1Clock);
    ul1SnapshotTrigger = 1'b0;
    waitStrobe("strobe2_start");
    repeat (STROBE_TICKS) tick();
    repeat (3) tick();
    chk1("pre_async_fval", ul1FrameValid, 1'b1);
    #2 ul1Reset = 1'b1;
    #1;
    chk1("async_fval", ul1FrameValid, 1'b0);
    chk1("async_lval", ul1LineValid, 1'b0);
    chk1("async_pixclk", ul1PixelClock, 1'b0);
    chk16("async_data", 16'(ul12PixelData), 16'd0);
    chk16("async_count", ul16FrameCount, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
